// File: rtl/jk_button_ctrl.sv
// Push-button front end for a JK flip-flop: synchronises two raw buttons, debounces
// them as one 2-bit vector and turns each accepted press into a single-cycle J/K command.
module jk_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_j,
  input  logic             btn_k,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic [CNT_W-1:0] press_count
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    FIRE,
    HELD
  } state_e;

  logic [1:0]       s1_q, s1_d;
  logic [1:0]       s2_q, s2_d;
  state_e           state_q, state_d;
  logic [1:0]       cand_q, cand_d;
  logic [DB_W-1:0]  cnt_q, cnt_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    s1_d    = {btn_j, btn_k};
    s2_d    = s1_q;
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    j_d     = 1'b0;
    k_d     = 1'b0;
    count_d = count_q;

    unique case (state_q)
      IDLE: begin
        if (s2_q != 2'b00) begin
          cand_d  = s2_q;
          cnt_d   = DB_ONE;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (s2_q == 2'b00) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (s2_q != cand_q) begin
          // A code change (e.g. 10 -> 11) restarts the stability window.
          cand_d = s2_q;
          cnt_d  = DB_ONE;
        end else if (cnt_q == DB_LAST) begin
          j_d     = cand_q[1];
          k_d     = cand_q[0];
          count_d = count_q + CNT_W'(1);
          state_d = FIRE;
        end else begin
          cnt_d = cnt_q + DB_ONE;
        end
      end
      FIRE: begin
        cnt_d   = '0;
        state_d = HELD;
      end
      HELD: begin
        // Only an unbroken run of released samples re-arms the block.
        if (s2_q == 2'b00) begin
          if (cnt_q == DB_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + DB_ONE;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 2'b00;
      s2_q    <= 2'b00;
      state_q <= IDLE;
      cand_q  <= 2'b00;
      cnt_q   <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign j           = j_q;
  assign k           = k_q;
  assign busy        = busy_q;
  assign press_count = count_q;

endmodule
